// File: rtl/ps2_key_event_queue_pkg.sv
// Shared key indices, scan codes and parser types for the PS/2 key event queue.
// Decode helper maps (extended, byte) pairs onto the eight game keys.
package ps2_key_event_queue_pkg;

  localparam logic [2:0] KEY_S     = 3'd0;
  localparam logic [2:0] KEY_P     = 3'd1;
  localparam logic [2:0] KEY_R     = 3'd2;
  localparam logic [2:0] KEY_ESC   = 3'd3;
  localparam logic [2:0] KEY_UP    = 3'd4;
  localparam logic [2:0] KEY_DOWN  = 3'd5;
  localparam logic [2:0] KEY_LEFT  = 3'd6;
  localparam logic [2:0] KEY_RIGHT = 3'd7;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] key;
  } key_hit_t;

  // Keypad arrows share codes with the extended arrows, so ext gates them.
  function automatic key_hit_t decode(
    input logic       ext,
    input logic [7:0] code
  );
    key_hit_t r;
    r.hit = 1'b0;
    r.key = KEY_S;
    if (ext) begin
      case (code)
        SC_UP:    begin r.hit = 1'b1; r.key = KEY_UP;    end
        SC_DOWN:  begin r.hit = 1'b1; r.key = KEY_DOWN;  end
        SC_LEFT:  begin r.hit = 1'b1; r.key = KEY_LEFT;  end
        SC_RIGHT: begin r.hit = 1'b1; r.key = KEY_RIGHT; end
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_S:    begin r.hit = 1'b1; r.key = KEY_S;   end
        SC_P:    begin r.hit = 1'b1; r.key = KEY_P;   end
        SC_R:    begin r.hit = 1'b1; r.key = KEY_R;   end
        SC_ESC:  begin r.hit = 1'b1; r.key = KEY_ESC; end
        default: r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_event_queue_parser.sv
// Set-2 scan-code prefix FSM; emits a same-cycle make/break strobe
// and key index for the byte that completes a mapped sequence.
module ps2_scan_parser
  import ps2_key_event_queue_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       make,
  output logic       brk,
  output logic [2:0] key
);

  ps2_state_e state_q, state_d;
  logic       act;
  logic       is_ext;
  logic       is_brk;
  key_hit_t   hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    act     = 1'b0;
    is_ext  = 1'b0;
    is_brk  = 1'b0;
    if (valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (data == SC_EXT)      state_d = ST_EXT;
          else if (data == SC_BRK) state_d = ST_BRK;
          else                     act = 1'b1;
        end
        ST_EXT: begin
          if (data == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            act     = 1'b1;
            is_ext  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          act     = 1'b1;
          is_brk  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          act     = 1'b1;
          is_ext  = 1'b1;
          is_brk  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    hit  = decode(is_ext, data);
    make = act & hit.hit & ~is_brk;
    brk  = act & hit.hit & is_brk;
    key  = hit.key;
  end

endmodule

// File: rtl/ps2_key_event_queue.sv
// Held-key bitmap plus show-ahead press-event FIFO with sticky overflow
// between the PS/2 byte receiver and the game controller.
module ps2_key_event_queue
  import ps2_key_event_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLKBoard,
  input  logic                     RESETn,
  input  logic [7:0]               SCAN_DATA,
  input  logic                     SCAN_VALID,
  input  logic                     POP,
  input  logic                     CLR_OVF,
  output logic                     EVT_VALID,
  output logic [2:0]               EVT_CODE,
  output logic [$clog2(DEPTH):0]   EVT_COUNT,
  output logic [7:0]               KEY_HELD,
  output logic                     OVERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic          make;
  logic          brk;
  logic [2:0]    key;
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    held;
  logic          ovf;
  logic          push_req;
  logic          do_push;
  logic          do_pop;
  logic          full;
  logic          ovf_set;

  ps2_scan_parser u_parser (
    .clk   (CLKBoard),
    .rst_n (RESETn),
    .data  (SCAN_DATA),
    .valid (SCAN_VALID),
    .make  (make),
    .brk   (brk),
    .key   (key)
  );

  // A make of an already-held key is typematic repeat and never queues.
  assign push_req = make & ~held[key];
  assign full     = (count == FULL_CNT);
  assign do_pop   = POP & (count != '0);
  assign do_push  = push_req & (~full | do_pop);
  assign ovf_set  = push_req & full & ~do_pop;

  always_ff @(posedge CLKBoard or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      held   <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= key;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (make) held[key] <= 1'b1;
      if (brk)  held[key] <= 1'b0;
      if (ovf_set)      ovf <= 1'b1;
      else if (CLR_OVF) ovf <= 1'b0;
    end
  end

  assign EVT_VALID = (count != '0);
  assign EVT_CODE  = mem[rd_ptr];
  assign EVT_COUNT = count;
  assign KEY_HELD  = held;
  assign OVERFLOW  = ovf;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Scoreboard bench for ps2_key_event_queue: a queue of expected events
// plus held/overflow model, compared against the DUT after every step.
module tb_ps2_key_event_queue;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] scan_data;
  logic       scan_valid;
  logic       pop;
  logic       clr_ovf;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic [2:0] evt_count;
  logic [7:0] key_held;
  logic       overflow;

  int   n_chk;
  int   n_fail;
  int   exp_q[$];
  bit [7:0] m_held;
  bit   m_ovf;

  logic [7:0] sc_tab [8] = '{8'h1B, 8'h4D, 8'h2D, 8'h76,
                             8'h75, 8'h72, 8'h6B, 8'h74};

  ps2_key_event_queue #(.DEPTH(DEPTH)) dut (
    .CLKBoard   (clk),
    .RESETn     (rst_n),
    .SCAN_DATA  (scan_data),
    .SCAN_VALID (scan_valid),
    .POP        (pop),
    .CLR_OVF    (clr_ovf),
    .EVT_VALID  (evt_valid),
    .EVT_CODE   (evt_code),
    .EVT_COUNT  (evt_count),
    .KEY_HELD   (key_held),
    .OVERFLOW   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"}, int'(evt_valid), int'(exp_q.size() != 0));
    check({tag, ".count"}, int'(evt_count), exp_q.size());
    check({tag, ".held"}, int'(key_held), int'(m_held));
    check({tag, ".ovf"}, int'(overflow), int'(m_ovf));
    if (exp_q.size() != 0)
      check({tag, ".code"}, int'(evt_code), exp_q[0]);
  endtask

  // Called at a negedge; byte is sampled at the following posedge.
  task automatic send_byte(input logic [7:0] b, input bit p = 0,
                           input bit c = 0);
    scan_data  = b;
    scan_valid = 1'b1;
    pop        = p;
    clr_ovf    = c;
    @(negedge clk);
    scan_valid = 1'b0;
    pop        = 1'b0;
    clr_ovf    = 1'b0;
  endtask

  task automatic key_evt(input int k, input bit is_brk,
                         input bit p = 0, input bit c = 0);
    bit set;
    set = 0;
    if (k >= 4) send_byte(8'hE0);
    if (is_brk) send_byte(8'hF0);
    send_byte(sc_tab[k], p, c);
    if (p && exp_q.size() != 0) void'(exp_q.pop_front());
    if (is_brk) begin
      m_held[k] = 1'b0;
    end else if (!m_held[k]) begin
      m_held[k] = 1'b1;
      if (exp_q.size() < DEPTH) exp_q.push_back(k);
      else set = 1;
    end
    if (set) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  task automatic tap(input int k);
    key_evt(k, 0);
    key_evt(k, 1);
  endtask

  task automatic pop_pulse();
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic pop_evt(input string tag, input int want);
    check({tag, ".head"}, int'(evt_code), want);
    pop_pulse();
    check_state(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    m_held = '0;
    m_ovf  = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    m_held = '0;
    m_ovf = 1'b0;
    scan_data = '0;
    scan_valid = 1'b0;
    pop = 1'b0;
    clr_ovf = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state("reset");
    check("reset.code", int'(evt_code), 0);

    key_evt(4, 0);
    check_state("up_make");
    check("up_make.held", int'(key_held), 8'h10);
    key_evt(4, 0);
    key_evt(4, 0);
    check_state("up_repeat");
    check("up_repeat.count", int'(evt_count), 1);
    key_evt(4, 1);
    check_state("up_break");

    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'h76);
    send_byte(8'hFA);
    check_state("keypad_rej");
    pop_evt("drain_up", 4);

    for (int k = 0; k < 5; k++) tap(k);
    check_state("ovf_fill");
    check("ovf_fill.ovf", int'(overflow), 1);
    for (int k = 0; k < 4; k++) pop_evt("ovf_drain", k);
    send_byte(8'h00, 0, 1);
    m_ovf = 1'b0;
    check_state("clr_ovf");

    for (int k = 0; k < 4; k++) tap(k);
    key_evt(7, 0, 0, 1);
    check_state("set_wins");
    key_evt(7, 1);
    send_byte(8'h00, 0, 1);
    m_ovf = 1'b0;
    check_state("clr2");

    key_evt(4, 0, 1);
    check_state("full_push_pop");
    check("full_push_pop.count", int'(evt_count), 4);
    for (int k = 1; k < 5; k++) pop_evt("fpp_drain", k);

    pop_pulse();
    check_state("pop_empty");
    key_evt(4, 1);
    key_evt(0, 0, 1);
    check_state("empty_push_pop");

    do_reset();
    check_state("reset2");
    tap(2);
    send_byte(8'hE0);
    do_reset();
    send_byte(8'h75);
    check_state("mid_reset");
    check("mid_reset.held", int'(key_held), 0);

    key_evt(5, 0);
    key_evt(6, 0);
    key_evt(5, 1);
    check_state("dn_lt");
    pop_evt("dn_pop", 5);
    pop_evt("lt_pop", 6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_queue.md
# ps2_key_event_queue

Converts the raw PS/2 set-2 scan-code byte stream into debounced key-press events for the eight game keys (S, P, R, ESC, UP, DOWN, LEFT, RIGHT). Events are buffered in a small FIFO so that the snake game controller, which runs on a slow game tick, never loses a direction change that arrives between ticks. The block sits between the PS/2 byte receiver (upstream) and the snake game controller (downstream). It also publishes a live held-key bitmap.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- CLKBoard  in  1  100 MHz board clock; only clock
- RESETn  in  1  asynchronous, active-low reset
- SCAN_DATA  in  8  received scan-code byte
- SCAN_VALID  in  1  one-cycle strobe; SCAN_DATA valid
- POP  in  1  consumer takes head event this cycle
- CLR_OVF  in  1  clears OVERFLOW
- EVT_VALID  out  1  FIFO non-empty
- EVT_CODE  out  3  head event key index: S=0, P=1, R=2, ESC=3, UP=4, DOWN=5, LEFT=6, RIGHT=7
- EVT_COUNT  out  log2(DEPTH)+1  occupancy
- KEY_HELD  out  8  bit i = key i currently down
- OVERFLOW  out  1  sticky; a press event was dropped because the FIFO was full

## Operation
- Parser FSM states: IDLE, EXT (seen E0), BRK (seen F0), EXT_BRK (seen E0 F0). The FSM advances only on SCAN_VALID.
- IDLE transitions:
  - E0 → EXT.
  - F0 → BRK.
  - Any other byte is decoded as a non-extended make, then the FSM stays in IDLE.
- EXT transitions:
  - F0 → EXT_BRK.
  - Any other byte is decoded as an extended make → IDLE.
- BRK and EXT_BRK: any byte is decoded as a non-extended or extended break respectively → IDLE.
- Non-extended decode: 1B→S, 4D→P, 2D→R, 76→ESC.
- Extended decode: 75→UP, 72→DOWN, 6B→LEFT, 74→RIGHT.
- Unmapped combinations produce no event and do not change KEY_HELD. This covers keypad 75/72/6B/74 without E0, extended 1B, FA, AA, E1 and similar.
- Make of key k:
  - If KEY_HELD[k]=0: set KEY_HELD[k] and push k.
  - If KEY_HELD[k]=1: this is typematic auto-repeat; ignore it, no push.
- Break of key k: clear KEY_HELD[k]. No push.
- FIFO behaviour:
  - Show-ahead: EVT_CODE always shows the oldest entry and is don't-care while EVT_VALID=0.
  - POP with EVT_VALID=0 is ignored.
  - Push when full without a simultaneous POP: the new event is dropped, the FIFO contents are unchanged, and OVERFLOW is set.
  - Push and POP in the same cycle when full: both happen, count is unchanged, no overflow.
  - Push and POP in the same cycle when empty: the pop is ignored and the push is accepted.
  - Read and write pointers wrap modulo DEPTH. EVT_COUNT saturates at neither end; it stays within 0..DEPTH.
- OVERFLOW:
  - Cleared by CLR_OVF.
  - If set and clear happen in the same cycle, set wins.

## Timing
- All state is updated on the rising edge of CLKBoard.
- Reset values: FSM=IDLE, pointers=0, EVT_VALID=0, EVT_COUNT=0, EVT_CODE=0, KEY_HELD=0, OVERFLOW=0.
- Latency: a SCAN_VALID byte completing a make at edge N gives EVT_VALID=1 and KEY_HELD updated after edge N.
- POP at edge N: the next entry is presented after edge N.
- Back-to-back SCAN_VALID on consecutive cycles must be handled.
- Reset asserted mid-sequence (e.g. after E0) discards the prefix, the held state and all queued events.

## Structure
- Shared package holds:
  - Key index constants (KEY_S..KEY_RIGHT).
  - Scan-code constants (SC_EXT=E0, SC_BRK=F0, and the eight key codes).
- One sub-module, ps2_scan_parser:
  - Contains the FSM and the decode logic.
  - Outputs a one-cycle make/break strobe plus a 3-bit key index.
- The top level holds KEY_HELD, the FIFO storage, the pointers and OVERFLOW.

## Test plan
- Reset: after reset deassert, EVT_VALID=0, EVT_COUNT=0, KEY_HELD=00, OVERFLOW=0.
- Extended press and repeat:
  - Bytes E0,75 → EVT_VALID=1, EVT_CODE=4, KEY_HELD=10h.
  - Repeat E0,75 twice → EVT_COUNT stays 1.
  - E0,F0,75 → KEY_HELD=00.
- Keypad rejection: byte 75 alone, and byte 76 after E0 → no events.
- Overflow, DEPTH=4:
  - Press S, P, R, ESC, UP with releases between and no POP → EVT_COUNT=4, OVERFLOW=1.
  - Four POPs yield codes 0,1,2,3.
  - CLR_OVF → OVERFLOW=0.
- Full with simultaneous push and pop:
  - FIFO holds 0,1,2,3; press UP with POP asserted in the same cycle → EVT_COUNT=4, OVERFLOW=0.
  - Drain yields 1,2,3,4.
- Reset mid-sequence: send E0, assert RESETn low then high, send 75 → no event, KEY_HELD=00.
